irq_pending_latch: RTL and testbench
====================================

IRQ_PENDING_LATCH -- requirements
Module: irq_pending_latch

Interface
REQ-001 SHALL have ports: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports: req  input  4  raw level request lines, one per source.
REQ-004 SHALL have ports: mask  input  4  per-source enable, 1 = enabled.
REQ-005 SHALL have ports: enc_din  output  4  masked pending vector, drives downstream 4-to-2 priority encoder din.
REQ-006 SHALL have ports: enc_dout  input  2  encoder index of selected source.
REQ-007 SHALL have ports: enc_error  input  1  encoder flag, 1 = enc_din all zero.
REQ-008 SHALL have ports: irq_valid  output  1  registered grant valid.
REQ-009 SHALL have ports: irq_id  output  2  registered granted source index.
REQ-010 SHALL have ports: irq_ready  input  1  consumer accepts grant.
REQ-011 SHALL have ports: pending  output  4  raw pending register, unmasked.
REQ-012 SHALL have ports: ovf  output  4  sticky per-source lost-event flags (see Configuration).

Function
REQ-013 SHALL register req into req_q each cycle; edge[i] = req[i] & ~req_q[i].
REQ-014 SHALL set pending[i] at the clock edge where edge[i]=1.
REQ-015 SHALL drive enc_din = pending & mask combinationally.
REQ-016 SHALL load output stage only when irq_valid=0: irq_valid <= ~enc_error, irq_id <= enc_dout.
REQ-017 SHALL hold irq_valid and irq_id stable while irq_valid=1 and irq_ready=0, even if mask or pending change.
REQ-018 Accept = irq_valid & irq_ready; on accept SHALL clear irq_valid and pending[irq_id] at that edge.
REQ-019 After accept SHALL insert exactly one bubble cycle (irq_valid=0) before next grant loads; max throughput one grant per 2 cycles.
REQ-020 Latency: req rises before edge k -> pending set at edge k -> irq_valid=1 after edge k+1 (output idle, bit enabled).
REQ-021 Simultaneous edge[i] and accept-clear of same i SHALL leave pending[i]=1 (set wins).
REQ-022 Masked pending bits SHALL remain pending and SHALL be granted once unmasked.
REQ-023 irq_ready while irq_valid=0 SHALL have no effect.

Reset
REQ-024 rst=1 SHALL at next edge clear req_q, pending, irq_valid, irq_id, ovf to 0; rst overrides all other updates.
REQ-025 A req line high when rst deasserts SHALL produce an edge (req_q=0) in the first active cycle.
REQ-026 Reset mid-handshake SHALL drop the grant; no pending state survives.

Configuration
REQ-027 Macro IRQ_PENDING_OVF_EN defined: ovf[i] SHALL set when edge[i]=1 while pending[i]=1 and not cleared that cycle; sticky until rst.
REQ-028 Macro IRQ_PENDING_OVF_EN undefined: ovf SHALL be tied 4'b0000 and no overflow logic instantiated.

Verification
Bench instantiates priority_4to2_encoder in the loop (enc_din -> din, dout/error -> enc_dout/enc_error).
REQ-029 req=4'b0100, mask=4'hF, irq_ready=1 -> irq_valid=1, irq_id=2 two edges later; accepted; pending=4'b0000 next cycle.
REQ-030 req 0->4'b1010 same cycle, ready=1 -> grants for both sources in encoder priority order, separated by one bubble cycle; pending returns to 0.
REQ-031 pending=4'b0001, mask=4'b0000 -> irq_valid stays 0; set mask=4'b0001 -> irq_valid=1, irq_id=0 next edge.
REQ-032 irq_valid=1, irq_ready=0 for 5 cycles while req[3] rises -> irq_id unchanged until accept; source 3 granted after bubble.
REQ-033 With IRQ_PENDING_OVF_EN: pulse req[1] twice before accept -> ovf=4'b0010; without macro -> ovf=4'b0000.
REQ-034 Assert rst while irq_valid=1 -> next cycle irq_valid=0, pending=0, ovf=0; req held high -> new grant after release.

Source files
------------

// File: rtl/irq_pending_latch.sv
// rtl/irq_pending_latch.sv - edge-latched IRQ pending register with registered grant stage
// Optional overflow tracking: define IRQ_PENDING_OVF_EN.
module irq_pending_latch (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] mask,
  output logic [3:0] enc_din,
  input  logic [1:0] enc_dout,
  input  logic       enc_error,
  output logic       irq_valid,
  output logic [1:0] irq_id,
  input  logic       irq_ready,
  output logic [3:0] pending,
  output logic [3:0] ovf
);

  logic [3:0] req_q;
  logic [3:0] req_edge;
  logic [3:0] clear_vec;
  logic       accept;

  assign req_edge = req & ~req_q;
  assign accept   = irq_valid & irq_ready;
  assign enc_din  = pending & mask;

  always_comb begin
    clear_vec = 4'b0000;
    if (accept) clear_vec[irq_id] = 1'b1;
  end

  // A new edge wins over an accept-clear of the same source.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= 4'b0000;
      pending <= 4'b0000;
    end else begin
      req_q   <= req;
      pending <= (pending & ~clear_vec) | req_edge;
    end
  end

  // The grant only reloads while idle, which yields one bubble after every accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_valid <= 1'b0;
      irq_id    <= 2'd0;
    end else if (!irq_valid) begin
      irq_valid <= ~enc_error;
      irq_id    <= enc_dout;
    end else if (irq_ready) begin
      irq_valid <= 1'b0;
    end
  end

`ifdef IRQ_PENDING_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 4'b0000;
    end else begin
      ovf <= ovf | (req_edge & pending & ~clear_vec);
    end
  end
`else
  assign ovf = 4'b0000;
`endif

endmodule

// File: tb/tb_irq_pending_latch.sv
// tb/tb_irq_pending_latch.sv - self-checking bench for irq_pending_latch with encoder in the loop
module tb_irq_pending_latch;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] mask;
  logic [3:0] enc_din;
  logic [1:0] enc_dout;
  logic       enc_error;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic       irq_ready;
  logic [3:0] pending;
  logic [3:0] ovf;

  int n_checks = 0;
  int n_errors = 0;

  // reference state, one entry per source
  bit m_req_q [4];
  bit m_pend  [4];
  bit m_ovf   [4];
  bit m_valid;
  int m_id;

  always #5 clk = ~clk;

  // stand-in for priority_4to2_encoder: highest set index wins
  always_comb begin
    enc_dout  = 2'd0;
    enc_error = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (enc_din[i]) begin
        enc_dout  = i[1:0];
        enc_error = 1'b0;
      end
    end
  end

  irq_pending_latch dut (
    .clk(clk), .rst(rst), .req(req), .mask(mask),
    .enc_din(enc_din), .enc_dout(enc_dout), .enc_error(enc_error),
    .irq_valid(irq_valid), .irq_id(irq_id), .irq_ready(irq_ready),
    .pending(pending), .ovf(ovf)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pack(input bit v [4]);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = v[i];
    return r;
  endfunction

  // One clock: apply inputs, advance the reference by the rules, compare after the edge.
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] mk, input logic rdy);
    bit n_pend [4];
    bit n_ovf  [4];
    bit n_valid;
    int n_id;
    int best;
    @(negedge clk);
    rst = r; req = rq; mask = mk; irq_ready = rdy;
    n_valid = m_valid;
    n_id    = m_id;
    for (int i = 0; i < 4; i++) begin
      bit rose, cleared;
      rose    = rq[i] && !m_req_q[i];
      cleared = m_valid && rdy && (m_id == i);
      n_pend[i] = rose || (m_pend[i] && !cleared);
`ifdef IRQ_PENDING_OVF_EN
      n_ovf[i] = m_ovf[i] || (rose && m_pend[i] && !cleared);
`else
      n_ovf[i] = 1'b0;
`endif
    end
    if (m_valid) begin
      if (rdy) n_valid = 1'b0;
    end else begin
      best = -1;
      for (int i = 0; i < 4; i++) if (m_pend[i] && mk[i]) best = i;
      n_valid = (best >= 0);
      n_id    = (best >= 0) ? best : 0;
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 4; i++) begin
        m_req_q[i] = 1'b0; m_pend[i] = 1'b0; m_ovf[i] = 1'b0;
      end
      m_valid = 1'b0;
      m_id    = 0;
    end else begin
      for (int i = 0; i < 4; i++) m_req_q[i] = rq[i];
      m_pend  = n_pend;
      m_ovf   = n_ovf;
      m_valid = n_valid;
      m_id    = n_id;
    end
    #1;
    check("pending", {4'h0, pending}, {4'h0, pack(m_pend)});
    check("enc_din", {4'h0, enc_din}, {4'h0, pack(m_pend) & mk});
    check("irq_valid", {7'h0, irq_valid}, {7'h0, m_valid});
    if (m_valid) check("irq_id", {6'h0, irq_id}, m_id[7:0]);
    check("ovf", {4'h0, ovf}, {4'h0, pack(m_ovf)});
  endtask

  initial begin
    rst = 1'b1; req = 4'h0; mask = 4'h0; irq_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_req_q[i] = 1'b0; m_pend[i] = 1'b0; m_ovf[i] = 1'b0;
    end
    m_valid = 1'b0; m_id = 0;

    // reset state
    step(1, 4'h0, 4'hF, 0);
    step(1, 4'h0, 4'hF, 0);
    check("rst_valid", {7'h0, irq_valid}, 8'h0);
    check("rst_pending", {4'h0, pending}, 8'h0);

    // single source, two-edge latency then accept
    step(0, 4'b0100, 4'hF, 1);
    check("s1_pending", {4'h0, pending}, 8'h04);
    step(0, 4'b0100, 4'hF, 1);
    check("s1_grant", {5'h0, irq_valid, irq_id}, 8'h06);
    step(0, 4'b0100, 4'hF, 1);
    check("s1_cleared", {3'h0, irq_valid, pending}, 8'h00);
    step(0, 4'b0000, 4'hF, 1);

    // two simultaneous sources, one bubble between grants
    step(0, 4'b1010, 4'hF, 1);
    step(0, 4'b1010, 4'hF, 1);
    check("s2_first", {5'h0, irq_valid, irq_id}, 8'h07);
    step(0, 4'b1010, 4'hF, 1);
    check("s2_bubble", {3'h0, irq_valid, pending}, 8'h02);
    step(0, 4'b1010, 4'hF, 1);
    check("s2_second", {5'h0, irq_valid, irq_id}, 8'h05);
    step(0, 4'b1010, 4'hF, 1);
    check("s2_done", {4'h0, pending}, 8'h00);
    step(0, 4'b0000, 4'hF, 1);

    // masked source stays pending until enabled
    step(0, 4'b0001, 4'h0, 1);
    step(0, 4'b0001, 4'h0, 1);
    step(0, 4'b0001, 4'h0, 1);
    check("s3_masked", {3'h0, irq_valid, pending}, 8'h01);
    step(0, 4'b0001, 4'b0001, 1);
    check("s3_unmask", {5'h0, irq_valid, irq_id}, 8'h04);
    step(0, 4'b0000, 4'b0001, 1);

    // grant held under backpressure while a higher source arrives
    step(0, 4'b0001, 4'hF, 0);
    step(0, 4'b0001, 4'hF, 0);
    for (int k = 0; k < 5; k++) step(0, 4'b1001, 4'hF, 0);
    check("s4_held", {5'h0, irq_valid, irq_id}, 8'h04);
    step(0, 4'b1001, 4'hF, 1);
    step(0, 4'b1001, 4'hF, 1);
    check("s4_next", {5'h0, irq_valid, irq_id}, 8'h07);
    step(0, 4'b0000, 4'hF, 1);
    step(0, 4'b0000, 4'hF, 1);

    // lost event on source 1
    step(0, 4'b0010, 4'hF, 0);
    step(0, 4'b0000, 4'hF, 0);
    step(0, 4'b0010, 4'hF, 0);
`ifdef IRQ_PENDING_OVF_EN
    check("s5_ovf", {4'h0, ovf}, 8'h02);
`else
    check("s5_ovf", {4'h0, ovf}, 8'h00);
`endif
    step(0, 4'b0000, 4'hF, 1);
    step(0, 4'b0000, 4'hF, 1);

    // reset during an outstanding grant
    step(0, 4'b0100, 4'hF, 0);
    step(0, 4'b0100, 4'hF, 0);
    step(1, 4'b0100, 4'hF, 0);
    check("s6_rst", {irq_valid, ovf, 3'h0}, 8'h00);
    check("s6_rst_pend", {4'h0, pending}, 8'h00);
    step(0, 4'b0100, 4'hF, 1);
    step(0, 4'b0100, 4'hF, 1);
    check("s6_regrant", {5'h0, irq_valid, irq_id}, 8'h06);

    // randomized traffic against the reference
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 49) == 0), 4'($urandom), 4'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
